spi_sensor_reader: RTL and testbench

Parametrised SPI master that reads fixed-length frames from a read-only serial sensor or ADC. It generates ss_n and sclk from clk, shifts in FRAME_BITS bits of miso, and extracts the field [DATA_MSB:DATA_LSB]. The result goes to memory/downstream logic over a valid/ready handshake. Everything is synchronous to clk: sclk is a registered output, never used as a clock.

---
 rtl/spi_sensor_reader_if.sv | 24 ++
 rtl/spi_sensor_reader.sv | 167 ++++++++++++++++
 tb/tb_spi_sensor_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sensor_reader_if.sv
// Bus bundle for spi_sensor_reader: the SPI pins toward the sensor and the
// valid/ready result stream toward downstream logic.
interface spi_sensor_reader_if #(
  parameter int DATA_W = 8
) ();
  logic              ss_n;
  logic              sclk;
  logic              miso;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              overrun;
  logic              frame_err;

  modport master (
    output ss_n, sclk, data_out, data_valid, overrun, frame_err,
    input  miso, data_ready
  );

  modport slave (
    input  ss_n, sclk, data_out, data_valid, overrun, frame_err,
    output miso, data_ready
  );
endinterface

// File: rtl/spi_sensor_reader.sv
// SPI master reading fixed-length frames from a read-only sensor/ADC and
// delivering one field per frame. Optional upper-bit check: SPI_FRAME_CHECK_EN.
module spi_sensor_reader #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_MSB   = 11,
  parameter int DATA_LSB   = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_IDLE    = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic busy,
  spi_sensor_reader_if.master bus
);

  localparam int T_MAX0 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int T_MAX  = (T_MAX0 > CS_IDLE) ? T_MAX0 : CS_IDLE;
  localparam int TW     = $clog2(T_MAX + 1);
  localparam int BW     = $clog2(FRAME_BITS + 1);

  localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(CS_IDLE - 1);
  localparam logic [BW-1:0] BITS_ALL   = BW'(FRAME_BITS);

  if (CLK_DIV < 1 || FRAME_BITS < 2 || FRAME_BITS > 32 || DATA_LSB < 0 ||
      DATA_MSB >= FRAME_BITS || DATA_LSB > DATA_MSB ||
      CS_SETUP < 1 || CS_IDLE < 1) begin : g_param_err
    $error("spi_sensor_reader: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t                    state, state_next;
  logic [TW-1:0]             timer;
  logic [BW-1:0]             bit_cnt;
  logic [FRAME_BITS-1:0]     shreg;
  logic                      sclk_q;
  logic                      ss_n_c;
  logic                      half_done;
  logic                      frame_done;
  logic [DATA_MSB-DATA_LSB:0] data_q;
  logic                      valid_q;
  logic                      overrun_q;

  assign half_done  = (timer == DIV_LAST);
  // The frame ends one full high half-period after the last sampling edge.
  assign frame_done = (state == S_SHIFT) && half_done && sclk_q && (bit_cnt == BITS_ALL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: default first so no path through the case leaves state_next
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_SETUP;
      S_SETUP: if (timer == SETUP_LAST) state_next = S_SHIFT;
      S_SHIFT: if (frame_done) state_next = S_HOLD;
      S_HOLD:  if (timer == IDLE_LAST) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    ss_n_c = (state == S_IDLE) || (state == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk_q  <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          sclk_q  <= 1'b1;
        end
        S_SETUP: begin
          if (timer == SETUP_LAST) begin
            timer  <= '0;
            sclk_q <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SHIFT: begin
          if (half_done) begin
            timer <= '0;
            if (!sclk_q) begin
              // Rising sclk: the sensor has held this bit since the fall.
              sclk_q  <= 1'b1;
              shreg   <= (shreg << 1) | {{(FRAME_BITS-1){1'b0}}, bus.miso};
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt != BITS_ALL) begin
              sclk_q <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_HOLD: begin
          if (timer == IDLE_LAST) timer <= '0;
          else                    timer <= timer + 1'b1;
        end
        default: timer <= '0;
      endcase
    end
  end

  // A new result always wins over a same-edge transfer; it counts as an
  // overrun only when the held result was not being consumed.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (frame_done) begin
        data_q    <= shreg[DATA_MSB:DATA_LSB];
        valid_q   <= 1'b1;
        overrun_q <= valid_q && !bus.data_ready;
      end else if (valid_q && bus.data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SPI_FRAME_CHECK_EN
  logic upper_set;
  logic err_q;

  if (DATA_MSB < FRAME_BITS - 1) begin : g_chk
    assign upper_set = |shreg[FRAME_BITS-1:DATA_MSB+1];
  end else begin : g_no_chk
    assign upper_set = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn)           err_q <= 1'b0;
    else if (frame_done) err_q <= upper_set;
  end

  assign bus.frame_err = err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.ss_n       = ss_n_c;
  assign bus.sclk       = sclk_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_spi_sensor_reader.sv
// Directed bench for spi_sensor_reader: a 16-bit/CLK_DIV=2 instance for the
// main scenarios and a 12-bit/CLK_DIV=1 instance for the generic case.
module tb_spi_sensor_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic start_a, start_g;
  logic busy_a, busy_g;

`ifdef SPI_FRAME_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  spi_sensor_reader_if #(.DATA_W(8))  bus_a ();
  spi_sensor_reader_if #(.DATA_W(12)) bus_g ();

  spi_sensor_reader #(
    .CLK_DIV(2), .FRAME_BITS(16), .DATA_MSB(11), .DATA_LSB(4),
    .CS_SETUP(2), .CS_IDLE(4)
  ) u_dut (
    .clk(clk), .rstn(rstn), .start(start_a), .busy(busy_a), .bus(bus_a.master)
  );

  spi_sensor_reader #(
    .CLK_DIV(1), .FRAME_BITS(12), .DATA_MSB(11), .DATA_LSB(0),
    .CS_SETUP(2), .CS_IDLE(4)
  ) u_dut_g (
    .clk(clk), .rstn(rstn), .start(start_g), .busy(busy_g), .bus(bus_g.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sensor models: load a frame when ss_n falls (sclk is high then), and
  // present the next bit, MSB first, after every sclk fall.
  logic [15:0] frames_a[$];
  logic [15:0] cur_a = '0;
  int          idx_a = 0;
  always @(negedge bus_a.ss_n or negedge bus_a.sclk) begin
    if (bus_a.sclk) begin
      if (frames_a.size() > 0) cur_a = frames_a.pop_front();
      else                     cur_a = '0;
      idx_a = 15;
    end else if (!bus_a.ss_n && idx_a >= 0) begin
      bus_a.miso = cur_a[idx_a];
      idx_a--;
    end
  end

  logic [11:0] frames_g[$];
  logic [11:0] cur_g = '0;
  int          idx_g = 0;
  always @(negedge bus_g.ss_n or negedge bus_g.sclk) begin
    if (bus_g.sclk) begin
      if (frames_g.size() > 0) cur_g = frames_g.pop_front();
      else                     cur_g = '0;
      idx_g = 11;
    end else if (!bus_g.ss_n && idx_g >= 0) begin
      bus_g.miso = cur_g[idx_g];
      idx_g--;
    end
  end

  // Pin monitor for instance A, sampled mid-cycle.
  int         low_cnt = 0, last_low = 0, high_cnt = 0, last_high = 0;
  int         fall_cnt = 0, sclk_viol = 0, ovr_cnt = 0, valid_cnt = 0, xfer_cnt = 0;
  logic       prev_sclk = 1'b1;
  logic [7:0] got_a[$];
  always @(negedge clk) begin
    if (!bus_a.ss_n) begin
      low_cnt++;
      if (high_cnt > 0) last_high = high_cnt;
      high_cnt = 0;
    end else begin
      if (low_cnt > 0) last_low = low_cnt;
      low_cnt = 0;
      high_cnt++;
      if (!bus_a.sclk) sclk_viol++;
    end
    if (prev_sclk && !bus_a.sclk) fall_cnt++;
    prev_sclk = bus_a.sclk;
    if (bus_a.overrun) ovr_cnt++;
    if (bus_a.data_valid) valid_cnt++;
    if (rstn && bus_a.data_valid && bus_a.data_ready) begin
      xfer_cnt++;
      got_a.push_back(bus_a.data_out);
    end
  end

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_a", busy_a, 1'b0);
  endtask

  task automatic run_a();
    pulse_start_a();
    wait_idle_a();
  endtask

  initial begin
    int n, f0, o0, x0, v0, q0;
    rstn = 1'b0; start_a = 1'b0; start_g = 1'b0;
    bus_a.data_ready = 1'b0; bus_g.data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n",    bus_a.ss_n, 1'b1);
    check("rst_sclk",    bus_a.sclk, 1'b1);
    check("rst_busy",    busy_a, 1'b0);
    check("rst_valid",   bus_a.data_valid, 1'b0);
    check("rst_data",    bus_a.data_out, 8'h00);
    check("rst_overrun", bus_a.overrun, 1'b0);
    check("rst_err",     bus_a.frame_err, 1'b0);
    check("rst_g_valid", bus_g.data_valid, 1'b0);
    rstn = 1'b1;

    // Basic read of 0x0AB0; latency counts the start-sampling edge as edge 1.
    frames_a.push_back(16'h0AB0);
    f0 = fall_cnt; x0 = xfer_cnt;
    pulse_start_a();
    n = 1;
    while (!bus_a.data_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency_a", n, 67);
    wait_idle_a();
    check("ss_low_len",  last_low, 66);
    check("sclk_falls",  fall_cnt - f0, 16);
    check("sclk_idle",   sclk_viol, 0);
    check("basic_data",  bus_a.data_out, 8'hAB);
    check("basic_valid", bus_a.data_valid, 1'b1);
    @(posedge clk); #1 bus_a.data_ready = 1'b1;
    @(posedge clk); #1 bus_a.data_ready = 1'b0;
    check("basic_consumed", bus_a.data_valid, 1'b0);
    check("basic_xfer",     xfer_cnt - x0, 1);

    // Back-pressure: second frame overwrites the first.
    frames_a.push_back(16'h0120);
    frames_a.push_back(16'h0340);
    o0 = ovr_cnt;
    run_a();
    check("bp_first", bus_a.data_out, 8'h12);
    run_a();
    check("bp_overrun", ovr_cnt - o0, 1);
    check("bp_data",    bus_a.data_out, 8'h34);
    check("bp_valid",   bus_a.data_valid, 1'b1);
    x0 = xfer_cnt;
    @(posedge clk); #1 bus_a.data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_xfer",  xfer_cnt - x0, 1);
    check("bp_drain", bus_a.data_valid, 1'b0);

    // Continuous: start held, three frames, each delivered once.
    frames_a.push_back(16'h0110);
    frames_a.push_back(16'h0220);
    frames_a.push_back(16'h0330);
    q0 = got_a.size(); o0 = ovr_cnt;
    @(posedge clk); #1 start_a = 1'b1;
    n = 0;
    while (got_a.size() < q0 + 3 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    start_a = 1'b0;
    wait_idle_a();
    repeat (4) @(posedge clk);
    #1;
    check("cont_count", got_a.size() - q0, 3);
    if (got_a.size() >= q0 + 3) begin
      check("cont_d0", got_a[q0],     8'h11);
      check("cont_d1", got_a[q0 + 1], 8'h22);
      check("cont_d2", got_a[q0 + 2], 8'h33);
    end
    check("cont_gap",     last_high, 5);
    check("cont_overrun", ovr_cnt - o0, 0);

    // Reset during bit 7, then a clean read.
    bus_a.data_ready = 1'b0;
    frames_a.push_back(16'h1230);
    frames_a.push_back(16'h0FF0);
    f0 = fall_cnt;
    pulse_start_a();
    n = 0;
    while (fall_cnt - f0 < 8 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    v0 = valid_cnt;
    rstn = 1'b0;
    @(posedge clk); #1;
    check("abort_ss_n", bus_a.ss_n, 1'b1);
    check("abort_sclk", bus_a.sclk, 1'b1);
    check("abort_busy", busy_a, 1'b0);
    rstn = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_valid", valid_cnt - v0, 0);
    run_a();
    check("abort_next_data",  bus_a.data_out, 8'hFF);
    check("abort_next_valid", bus_a.data_valid, 1'b1);
    @(posedge clk); #1 bus_a.data_ready = 1'b1;
    @(posedge clk); #1 bus_a.data_ready = 1'b0;

    // Upper-bit frame check.
    frames_a.push_back(16'h8AB0);
    run_a();
    check("chk_bad_data", bus_a.data_out, 8'hAB);
    check("chk_bad_err",  bus_a.frame_err, EXP_ERR);
    @(posedge clk); #1 bus_a.data_ready = 1'b1;
    @(posedge clk); #1 bus_a.data_ready = 1'b0;
    frames_a.push_back(16'h0AB0);
    run_a();
    check("chk_ok_data", bus_a.data_out, 8'hAB);
    check("chk_ok_err",  bus_a.frame_err, 1'b0);

    // Generic instance: 12-bit frame, whole-frame field, CLK_DIV=1.
    frames_g.push_back(12'hA5C);
    @(posedge clk); #1 start_g = 1'b1;
    @(posedge clk); #1 start_g = 1'b0;
    n = 1;
    while (!bus_g.data_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency_g", n, 27);
    check("gen_data",  bus_g.data_out, 12'hA5C);
    check("gen_err",   bus_g.frame_err, 1'b0);
    n = 0;
    while (busy_g && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("gen_idle", busy_g, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
